segre_mem_stage: RTL
====================

Name: segre_mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the ALU result as either a load/store address or a plain result, drives the data-memory request/grant/rvalid interface, and aligns store data and load data.
- Presents one registered result per instruction to the writeback stage.
- Stalls execute through a ready signal while a memory access is outstanding.

Parameters:
- WORD_SIZE, 32 (from segre_pkg), datapath width; the byte-lane logic is defined for 32 only.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset; asynchronous, active-low.
- ex_valid_i  in  1  execute presents an instruction.
- ex_ready_o  out  1  stage can accept; transfer occurs when ex_valid_i && ex_ready_o.
- alu_res_i  in  WORD_SIZE  ALU result; byte address for memory ops.
- mem_op_i  in  2  mem_op_e: MEM_NONE, MEM_LOAD, MEM_STORE.
- mem_size_i  in  2  mem_size_e: MEM_BYTE, MEM_HALF, MEM_WORD.
- mem_unsigned_i  in  1  load zero-extends when 1.
- store_data_i  in  WORD_SIZE  rs2 value for stores.
- rd_addr_i  in  REG_ADDR_W  destination register.
- rf_we_i  in  1  destination write enable.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  WORD_SIZE  word-aligned address, bits [1:0] = 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  WORD_SIZE  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  WORD_SIZE  load data.
- wb_valid_o  out  1  one-cycle pulse, result to writeback.
- wb_rd_addr_o  out  REG_ADDR_W  destination register.
- wb_rf_we_o  out  1  register write enable.
- wb_data_o  out  WORD_SIZE  result.
- misaligned_o  out  1  misaligned-access flag, valid with wb_valid_o.

Behaviour:
- Reset values: all outputs 0, state IDLE, ex_ready_o = 1 once reset deasserts.
- Reset mid-access: return to IDLE, drop the request, and ignore any later dmem_gnt_i or dmem_rvalid_i.
- FSM states: IDLE, REQ, RESP. ex_ready_o = (state == IDLE).
- IDLE, accept of MEM_NONE:
  - Next cycle: wb_valid_o = 1, wb_data_o = alu_res_i, wb_rf_we_o = rf_we_i.
  - Stay in IDLE; latency is 1 cycle, with back-to-back issue.
- IDLE, accept of a load or store:
  - Register the address, size, unsigned flag, byte enables, write data, rd and we; go to REQ.
- REQ:
  - dmem_req_o = 1 with stable address, be and wdata until dmem_gnt_i.
  - On grant, a store goes to IDLE, pulses wb_valid_o next cycle, and forces wb_rf_we_o = 0.
  - On grant, a load goes to RESP.
- RESP:
  - dmem_req_o = 0; wait for dmem_rvalid_i.
  - On rvalid, go to IDLE and pulse wb_valid_o next cycle with the extracted load data and wb_rf_we_o = the latched rf_we.
- Minimum load latency: accept T, req T+1, gnt T+1, rvalid T+2, wb_valid_o T+3. A new accept is possible at T+3.
- Lane rules, with off = addr[1:0]:
  - Byte: be = 4'b0001 << off; wdata = 4 copies of store_data[7:0].
  - Half: be = 4'b0011 << {addr[1], 0}; wdata = 2 copies of store_data[15:0].
  - Word: be = 4'b1111; wdata = store_data_i.
- Load extraction:
  - Shift rdata right by 8 × off.
  - Take [7:0] or [15:0] (word: all bits).
  - Sign-extend unless mem_unsigned_i is set.
- dmem_gnt_i and dmem_rvalid_i are ignored outside REQ and RESP respectively.
- Writeback never back-pressures.
- An accepted instruction ignores changes on the ex_* inputs.

Optional Feature:
- Macro SEGRE_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no memory request and stays in IDLE.
  - Next cycle: wb_valid_o = 1, wb_rf_we_o = 0, misaligned_o = 1, wb_data_o = faulting address.
- Undefined:
  - misaligned_o tied to 0.
  - Offending low address bits are ignored: half uses addr[1] only, word treats the access as aligned.

Decomposition:
- segre_pkg additions:
  - mem_op_e, mem_size_e, REG_ADDR_W.
  - Constants BE_BYTE = 4'b0001, BE_HALF = 4'b0011, BE_WORD = 4'b1111.
- Sub-module segre_mem_align, purely combinational:
  - Inputs: size, offset, unsigned, store data, read data.
  - Outputs: be, replicated wdata, extended load data.
- The FSM and pipeline registers stay in segre_mem_stage.

Test Plan:
- MEM_NONE, alu_res_i = 0x0000_1234, rf_we_i = 1, rd = 5 -> next cycle wb_valid_o = 1, wb_data_o = 0x0000_1234, wb_rd_addr_o = 5; a second op the following cycle is also accepted.
- Store byte, address 0x103, data 0xAABBCCDD -> dmem_addr_o = 0x100, dmem_be_o = 4'b1000, dmem_wdata_o = 0xDDDDDDDD; gnt delayed 3 cycles keeps the request stable; wb_rf_we_o = 0.
- Load half signed, address 0x202, rdata 0x8001_0000 -> wb_data_o = 0xFFFF_8001; the same case with mem_unsigned_i = 1 -> wb_data_o = 0x0000_8001.
- Load word with gnt at T+1 and rvalid at T+4 -> ex_ready_o low T+1..T+4, wb_valid_o at T+5 with rdata.
- Reset asserted while in RESP, then a stray dmem_rvalid_i after reset -> no wb_valid_o, state IDLE, dmem_req_o = 0.
- With SEGRE_MEM_MISALIGN_TRAP_EN, load word at address 0x301 -> no dmem_req_o; next cycle misaligned_o = 1, wb_rf_we_o = 0, wb_data_o = 0x301.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory stage.
package segre_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    is_misaligned = ((size == MEM_HALF) && off[0]) ||
                    ((size == MEM_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/segre_mem_align.sv
// Combinational byte-lane logic: store byte enables, store data replication
// and load data extraction with sign/zero extension.
module segre_mem_align
  import segre_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           off_i,
  input  logic                 unsigned_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] load_data_o
);

  logic [1:0]           eff_off;
  logic [WORD_SIZE-1:0] shifted;

  always_comb begin
    eff_off     = 2'b00;
    be_o        = BE_WORD;
    wdata_o     = store_data_i;
    shifted     = rdata_i;
    load_data_o = rdata_i;
    // Low address bits that don't fit the access size are dropped, so a
    // half uses only addr[1] and a word is always treated as aligned.
    case (size_i)
      MEM_BYTE: begin
        eff_off = off_i;
        be_o    = BE_BYTE << eff_off;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_HALF: begin
        eff_off = {off_i[1], 1'b0};
        be_o    = BE_HALF << eff_off;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        eff_off = 2'b00;
        be_o    = BE_WORD;
        wdata_o = store_data_i;
      end
    endcase
    shifted = rdata_i >> {eff_off, 3'b000};
    case (size_i)
      MEM_BYTE: load_data_o = unsigned_i ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: load_data_o = unsigned_i ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default:  load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/segre_mem_stage.sv
// Memory pipeline stage: IDLE/REQ/RESP FSM driving the data-memory interface
// and a registered writeback result. Optional SEGRE_MEM_MISALIGN_TRAP_EN
// turns misaligned half/word accesses into a flagged writeback without a request.
module segre_mem_stage
  import segre_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [WORD_SIZE-1:0]  alu_res_i,
  input  logic [1:0]            mem_op_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  input  logic [WORD_SIZE-1:0]  store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rf_we_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [WORD_SIZE-1:0]  dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [WORD_SIZE-1:0]  dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0]  dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_rf_we_o,
  output logic [WORD_SIZE-1:0]  wb_data_o,
  output logic                  misaligned_o
);

  mem_state_e            state_q;
  logic [WORD_SIZE-1:0]  addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [3:0]            be_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  we_q;
  logic                  store_q;

  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  wb_we_q;
  logic [WORD_SIZE-1:0]  wb_data_q;
  logic                  mis_q;

  logic                  idle;
  logic                  accept;
  logic                  is_mem;
  logic                  mis_acc;
  logic [1:0]            al_size;
  logic [1:0]            al_off;
  logic                  al_uns;
  logic [3:0]            al_be;
  logic [WORD_SIZE-1:0]  al_wdata;
  logic [WORD_SIZE-1:0]  al_load;

  assign idle   = (state_q == ST_IDLE);
  assign accept = ex_valid_i && ex_ready_o;
  assign is_mem = (mem_op_i == MEM_LOAD) || (mem_op_i == MEM_STORE);

`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
  assign mis_acc = is_mem && is_misaligned(mem_size_i, alu_res_i[1:0]);
`else
  assign mis_acc = 1'b0;
`endif

  // In IDLE the aligner sees the incoming op (for be/wdata); afterwards it
  // sees the latched op so load extraction is immune to ex_* changes.
  assign al_size = idle ? mem_size_i       : size_q;
  assign al_off  = idle ? alu_res_i[1:0]   : addr_q[1:0];
  assign al_uns  = idle ? mem_unsigned_i   : uns_q;

  segre_mem_align u_align (
    .size_i       (al_size),
    .off_i        (al_off),
    .unsigned_i   (al_uns),
    .store_data_i (store_data_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      store_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= alu_res_i;
              wb_rd_q    <= rd_addr_i;
              wb_we_q    <= rf_we_i;
            end else if (mis_acc) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= alu_res_i;
              wb_rd_q    <= rd_addr_i;
              wb_we_q    <= 1'b0;
              mis_q      <= 1'b1;
            end else begin
              addr_q  <= alu_res_i;
              size_q  <= mem_size_i;
              uns_q   <= mem_unsigned_i;
              be_q    <= al_be;
              wdata_q <= al_wdata;
              rd_q    <= rd_addr_i;
              we_q    <= rf_we_i;
              store_q <= (mem_op_i == MEM_STORE);
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt_i) begin
            if (store_q) begin
              state_q    <= ST_IDLE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= addr_q;
              wb_rd_q    <= rd_q;
              wb_we_q    <= 1'b0;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (dmem_rvalid_i) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b1;
            wb_data_q  <= al_load;
            wb_rd_q    <= rd_q;
            wb_we_q    <= we_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake: a transfer from execute happens on a cycle where
  // ex_valid_i && ex_ready_o; ready is held low while in reset.
  assign ex_ready_o   = rsn_i && idle;
  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = dmem_req_o && store_q;
  assign dmem_addr_o  = {addr_q[WORD_SIZE-1:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_rf_we_o   = wb_we_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = mis_q;

endmodule
